tpu_result_tx: RTL and testbench

TPU_RESULT_TX -- requirements
Module: tpu_result_tx

---
 rtl/tpu_result_tx.sv | 189 ++++++++++++++++++
 tb/tb_tpu_result_tx.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tpu_result_tx.sv
// tpu_result_tx
//   Buffers 16-bit result words from the TPU core and sends each one to an
//   external host as two bytes (low byte first). Each byte uses a 4-phase
//   request/acknowledge handshake on the host pins.
//
// Handshakes:
//   Core side (valid/ready): a word transfers on a rising clk edge where
//   in_valid && in_ready. in_data must be stable while in_valid is high.
//   in_ready depends only on registered occupancy, never on in_valid.
//   Host side (4-phase): out_strobe rises with out_byte already stable.
//   The host raises host_ack. The block drops out_strobe, and the host then
//   drops host_ack. out_byte holds through both the request and release phases.
//
// Ports:
//   clk, reset        sole clock; asynchronous active-high reset
//   in_data/in_valid  result word from the core, with its valid qualifier
//   in_ready          FIFO not full
//   out_byte          byte driven to the host pins (registered)
//   out_strobe        host request line (registered)
//   host_ack          host acknowledge, asynchronous, synchronized internally
//   busy              FIFO non-empty or a word is in flight
//   tx_count          words fully transmitted, modulo 256
//   fsm_state         debug view of the transmit FSM (IDLE=0, LO_REQ=1,
//                     LO_REL=2, HI_REQ=3, HI_REL=4)
//   occupancy         debug view of the FIFO word count
module tpu_result_tx #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [15:0]              in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [7:0]               out_byte,
    output logic                     out_strobe,
    input  logic                     host_ack,
    output logic                     busy,
    output logic [7:0]               tx_count,
    output logic [2:0]               fsm_state,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);
    localparam logic [AW:0]   CNT_ONE    = (AW+1)'(1);
    localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LO_REQ = 3'd1,
        LO_REL = 3'd2,
        HI_REQ = 3'd3,
        HI_REL = 3'd4
    } state_t;

    state_t        state;
    state_t        state_next;

    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_ptr_inc;
    logic [AW:0]   count;
    logic [AW:0]   count_next;
    logic          push;
    logic          pop;

    logic          ack_meta;
    logic          ack_s;

    logic [15:0]   head;
    logic [15:0]   head_after_pop;
    logic          strobe_next;
    logic [7:0]    byte_next;

    // ------------------------------------------------------------------
    // FIFO control
    // ------------------------------------------------------------------
    // Full blocks the push even when a pop happens on the same edge. The
    // ready path therefore never depends on the FSM.
    assign in_ready   = (count != FULL_COUNT);
    assign push       = in_valid && in_ready;
    // The head word leaves only when the high byte's release phase completes.
    // Until then the slot is not writable, so the word in flight stays intact.
    assign pop        = (state == HI_REL) && !ack_s;
    assign rd_ptr_inc = rd_ptr + PTR_ONE;
    assign head       = mem[rd_ptr];

    // After a pop, the next word is normally mem[rd_ptr+1]. If the FIFO held
    // only the outgoing word and a push lands on the same edge, the new word
    // is not in memory yet, so take it straight from in_data.
    assign head_after_pop = (count == CNT_ONE && push) ? in_data : mem[rd_ptr_inc];

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CNT_ONE;
            2'b01:   count_next = count - CNT_ONE;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr_inc;
            count <= count_next;
        end
    end

    // Storage has no reset. Occupancy alone decides which entries are valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end

    // ------------------------------------------------------------------
    // host_ack synchronizer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ack_meta <= 1'b0;
            ack_s    <= 1'b0;
        end else begin
            ack_meta <= host_ack;
            ack_s    <= ack_meta;
        end
    end

    // ------------------------------------------------------------------
    // Transmit FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // ------------------------------------------------------------------
    // Transmit FSM: next state
    // ------------------------------------------------------------------
    // IDLE never looks at ack_s, so a stray acknowledge there has no effect.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (count != '0) state_next = LO_REQ;
            LO_REQ:  if (ack_s)       state_next = LO_REL;
            LO_REL:  if (!ack_s)      state_next = HI_REQ;
            HI_REQ:  if (ack_s)       state_next = HI_REL;
            HI_REL:  if (!ack_s)      state_next = (count_next != '0) ? LO_REQ : IDLE;
            default:                  state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Transmit FSM: outputs
    // ------------------------------------------------------------------
    // The pin values are computed from state_next and then registered.
    // Strobe and byte therefore change together on one clock edge, with no
    // decode glitches. The byte is loaded only when a REQ phase is entered,
    // which keeps it stable through REQ and the following REL phase.
    always_comb begin
        strobe_next = (state_next == LO_REQ) || (state_next == HI_REQ);
        byte_next   = out_byte;
        if (state_next == LO_REQ && state != LO_REQ)
            byte_next = (state == HI_REL) ? head_after_pop[7:0] : head[7:0];
        else if (state_next == HI_REQ && state != HI_REQ)
            byte_next = head[15:8];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_strobe <= 1'b0;
            out_byte   <= 8'h00;
            tx_count   <= 8'h00;
        end else begin
            out_strobe <= strobe_next;
            out_byte   <= byte_next;
            if (pop) tx_count <= tx_count + 8'd1;
        end
    end

    assign busy      = (count != '0) || (state != IDLE);
    assign fsm_state = state;
    assign occupancy = count;

endmodule

// File: tb/tb_tpu_result_tx.sv
// tb_tpu_result_tx
//   Randomized bench for tpu_result_tx with DEPTH = 4. A host responder
//   process acknowledges strobes after random delays. A monitor compares
//   every byte the host sees with a queue of expected bytes, built from
//   accepted words as low byte then high byte. A word counter (mod 256)
//   models tx_count.
module tb_tpu_result_tx;

    localparam int DEPTH = 4;

    logic        clk;
    logic        reset;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_byte;
    logic        out_strobe;
    logic        host_ack;
    logic        busy;
    logic [7:0]  tx_count;
    logic [2:0]  fsm_state;
    logic [2:0]  occupancy;

    tpu_result_tx #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_byte   (out_byte),
        .out_strobe (out_strobe),
        .host_ack   (host_ack),
        .busy       (busy),
        .tx_count   (tx_count),
        .fsm_state  (fsm_state),
        .occupancy  (occupancy)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    logic [7:0] exp_q[$];
    logic [7:0] exp_tx;
    int         n_checks;
    int         n_pass;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // ---------------- host responder ----------------
    bit host_en;
    int ack_max;

    initial begin
        host_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (host_en && !reset) begin
                if (out_strobe && !host_ack) begin
                    repeat ($urandom_range(0, ack_max)) @(negedge clk);
                    host_ack = 1'b1;
                end else if (!out_strobe && host_ack) begin
                    repeat ($urandom_range(0, ack_max)) @(negedge clk);
                    host_ack = 1'b0;
                end
            end
        end
    end

    // ---------------- byte monitor ----------------
    logic       prev_strobe;
    logic [7:0] cap_byte;

    initial begin
        prev_strobe = 1'b0;
        cap_byte    = 8'h00;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_strobe = 1'b0;
            end else begin
                if (out_strobe && !prev_strobe) begin
                    if (exp_q.size() == 0) check("strobe_unexpected", 32'(out_strobe), 32'd0);
                    else check("byte", 32'(out_byte), 32'(exp_q.pop_front()));
                    cap_byte = out_byte;
                end else if (!out_strobe && prev_strobe) begin
                    check("byte_hold", 32'(out_byte), 32'(cap_byte));
                end
                prev_strobe = out_strobe;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_word(input logic [15:0] d);
        bit done;
        done = 1'b0;
        @(negedge clk);
        in_data  = d;
        in_valid = 1'b1;
        for (int i = 0; i < 500 && !done; i++) begin
            if (in_ready) begin
                @(posedge clk);
                done = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        #1;
        in_valid = 1'b0;
        if (done) begin
            exp_q.push_back(d[7:0]);
            exp_q.push_back(d[15:8]);
            exp_tx = exp_tx + 8'd1;
        end else begin
            check("push_accept", 32'(done), 32'd1);
        end
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 4000 && !ok; i++) begin
            @(negedge clk);
            if (!busy && exp_q.size() == 0) ok = 1'b1;
        end
        check("idle_reached", 32'(ok), 32'd1);
    endtask

    task automatic wait_strobe(input logic v);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (out_strobe == v) ok = 1'b1;
        end
        if (!ok) check("strobe_wait", 32'(out_strobe), 32'(v));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [15:0] w;
        int          n;
        int          strobe_seen;

        n_checks = 0;
        n_pass   = 0;
        exp_tx   = 8'd0;
        host_en  = 1'b0;
        ack_max  = 3;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 16'h0000;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_strobe",  32'(out_strobe), 32'd0);
        check("rst_byte",    32'(out_byte),   32'h00);
        check("rst_busy",    32'(busy),       32'd0);
        check("rst_tx",      32'(tx_count),   32'd0);
        check("rst_ready",   32'(in_ready),   32'd1);
        check("rst_state",   32'(fsm_state),  32'd0);
        check("rst_occ",     32'(occupancy),  32'd0);
        reset = 1'b0;

        // Single word, including the strobe latency after the push edge
        host_en = 1'b1;
        push_word(16'hA55A);
        @(negedge clk);
        check("lat_pre",    32'(out_strobe), 32'd0);
        @(negedge clk);
        check("lat_strobe", 32'(out_strobe), 32'd1);
        check("lat_byte",   32'(out_byte),   32'h5A);
        wait_idle();
        check("single_tx",    32'(tx_count),  32'd1);
        check("single_busy",  32'(busy),      32'd0);
        check("single_state", 32'(fsm_state), 32'd0);

        // A stray acknowledge while idle is ignored
        host_en  = 1'b0;
        @(negedge clk);
        host_ack = 1'b1;
        strobe_seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_strobe) strobe_seen++;
        end
        host_ack = 1'b0;
        repeat (4) @(negedge clk);
        check("idle_ack_strobe", 32'(strobe_seen), 32'd0);
        check("idle_ack_state",  32'(fsm_state),   32'd0);
        check("idle_ack_tx",     32'(tx_count),    32'(exp_tx));

        // Fill with the host stalled
        for (int i = 1; i <= DEPTH; i++) push_word(16'(i));
        @(negedge clk);
        check("fill_ready", 32'(in_ready),  32'd0);
        check("fill_occ",   32'(occupancy), 32'(DEPTH));
        in_data  = 16'h0005;
        in_valid = 1'b1;
        repeat (5) @(negedge clk);
        in_valid = 1'b0;
        check("fill_reject_occ", 32'(occupancy),  32'(DEPTH));
        check("fill_strobe",     32'(out_strobe), 32'd1);
        check("fill_byte",       32'(out_byte),   32'h01);
        host_en = 1'b1;
        wait_idle();
        check("fill_tx", 32'(tx_count), 32'(exp_tx));

        // Push and pop on the same edge at occupancy 2
        host_en = 1'b0;
        push_word(16'h2211);
        push_word(16'h4433);
        wait_strobe(1'b1);
        host_ack = 1'b1;
        repeat (3) @(negedge clk);
        check("ack_to_drop", 32'(out_strobe), 32'd0);
        host_ack = 1'b0;
        wait_strobe(1'b1);
        host_ack = 1'b1;
        wait_strobe(1'b0);
        host_ack = 1'b0;
        repeat (2) @(negedge clk);
        check("pp_state", 32'(fsm_state), 32'd4);
        check("pp_occ0",  32'(occupancy), 32'd2);
        in_data  = 16'h6655;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        exp_q.push_back(8'h55);
        exp_q.push_back(8'h66);
        exp_tx = exp_tx + 8'd1;
        @(negedge clk);
        check("pp_occ1", 32'(occupancy), 32'd2);
        host_en = 1'b1;
        wait_idle();
        check("pp_tx", 32'(tx_count), 32'(exp_tx));

        // Ten-word stream through the wrapping pointers with random ack delays
        ack_max = 4;
        for (int i = 0; i < 10; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            push_word(16'h1000 + 16'(i));
        end
        wait_idle();
        check("stream_tx", 32'(tx_count), 32'(exp_tx));

        // Reset during HI_REQ with three words queued
        host_en = 1'b0;
        for (int i = 0; i < 3; i++) push_word(16'($urandom_range(0, 65535)));
        wait_strobe(1'b1);
        host_ack = 1'b1;
        wait_strobe(1'b0);
        host_ack = 1'b0;
        wait_strobe(1'b1);
        check("hr_state", 32'(fsm_state), 32'd3);
        reset = 1'b1;
        #1;
        check("hr_strobe_async", 32'(out_strobe), 32'd0);
        exp_q.delete();
        exp_tx = 8'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        strobe_seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_strobe) strobe_seen++;
        end
        check("hr_no_strobe", 32'(strobe_seen), 32'd0);
        check("hr_busy",      32'(busy),        32'd0);
        check("hr_ready",     32'(in_ready),    32'd1);
        check("hr_tx",        32'(tx_count),    32'd0);
        host_en = 1'b1;
        ack_max = 2;
        push_word(16'($urandom_range(0, 65535)));
        wait_idle();
        check("hr_after_tx", 32'(tx_count), 32'(exp_tx));

        // tx_count wrap: bring the total since reset to 256, then one more
        ack_max = 0;
        n = 256 - int'(exp_tx);
        for (int i = 0; i < n; i++) begin
            w = 16'($urandom_range(0, 65535));
            push_word(w);
        end
        wait_idle();
        check("wrap_tx0", 32'(tx_count), 32'd0);
        push_word(16'($urandom_range(0, 65535)));
        wait_idle();
        check("wrap_tx1", 32'(tx_count), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
